// File: rtl/fpu_pkg.sv
// Shared definitions for the divide / square-root execution unit.
// Holds the IEEE-754 single-precision format constants, the FSM state
// encoding and the operand classification used after unpacking.
package fpu_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {IDLE, PREP, ITER, NORM} state_t;

    // Denormals are folded into ZERO: the unit flushes them on input.
    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_t;

endpackage

// File: rtl/fpu_divsqrt_unit_if.sv
// Command / result bundle between the FPU control unit and the
// divide / square-root execution unit.
//   master : drives start pulses and operands, observes result and status
//   slave  : the execution unit
interface fpu_divsqrt_unit_if;

    logic        div_start;
    logic        sqrt_start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        operation_ready;
    logic        div_by_zero;
    logic        invalid;

    modport master (
        output div_start, sqrt_start, operand_a, operand_b,
        input  result, operation_ready, div_by_zero, invalid
    );

    modport slave (
        input  div_start, sqrt_start, operand_a, operand_b,
        output result, operation_ready, div_by_zero, invalid
    );

endinterface

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 field splitter.
//   word : packed floating-point value
//   sign : sign bit
//   exp  : biased exponent field
//   man  : mantissa with the hidden bit restored (zero for ZERO class)
//   cls  : ZERO (incl. denormals), NORMAL, INF or NAN
module fpu_unpack
    import fpu_pkg::*;
#(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W
) (
    input  logic [EXP_W+MAN_W:0] word,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       man,
    output op_class_t            cls
);

    logic [MAN_W-1:0] frac;

    assign sign = word[EXP_W+MAN_W];
    assign exp  = word[EXP_W+MAN_W-1:MAN_W];
    assign frac = word[MAN_W-1:0];

    always_comb begin
        man = {1'b1, frac};
        cls = NORMAL;
        if (exp == '0) begin
            // denormal inputs are treated as zero
            cls = ZERO;
            man = '0;
        end else if (exp == '1) begin
            cls = (frac == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fpu_divsqrt_unit.sv
// Iterative single-precision divide / square-root unit.
// Radix-2 restoring iteration producing one quotient / root bit per clock,
// truncating rounding, denormals flushed to zero.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fpu_divsqrt_unit_if
//              div_start / sqrt_start one-cycle pulses (divide wins if both),
//              operand_a / operand_b captured on the accepted start edge,
//              result / div_by_zero / invalid held while operation_ready=1.
module fpu_divsqrt_unit
    import fpu_pkg::*;
#(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    fpu_divsqrt_unit_if.slave bus
);

    localparam int WW = 1 + EXP_W + MAN_W;  // word width
    localparam int MW = MAN_W + 1;          // mantissa incl. hidden bit
    localparam int QW = MAN_W + 2;          // divide quotient bits
    localparam int RW = MAN_W + 3;          // partial remainder
    localparam int SW = 2 * MW;             // sqrt radicand
    localparam int XW = EXP_W + 2;          // signed working exponent
    localparam int CW = 5;

    localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X   = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X  = '0;

    state_t state, state_nxt;

    logic [WW-1:0]        op_a, op_b;
    logic                 is_div;
    logic                 sign_r;
    logic signed [XW-1:0] exp_r;
    logic [RW-1:0]        rem;
    logic [QW-1:0]        q;
    logic [SW-1:0]        rad;
    logic [CW-1:0]        cnt;
    logic [WW-1:0]        result_r;
    logic                 ready_r, dbz_r, inv_r;

    logic                 sa, sb, sq;
    logic [EXP_W-1:0]     ea, eb;
    logic [MW-1:0]        ma, mb;
    op_class_t            ca, cb;

    fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(op_a), .sign(sa), .exp(ea), .man(ma), .cls(ca)
    );
    fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(op_b), .sign(sb), .exp(eb), .man(mb), .cls(cb)
    );

    assign sq = sa ^ sb;

    logic start_any;
    assign start_any = bus.div_start | bus.sqrt_start;

    // Special-case classification. Operands stay captured for the whole
    // operation, so this is evaluated in PREP for branching and again in
    // NORM to select the packed result.
    logic          special, spec_dbz, spec_inv;
    logic [WW-1:0] spec_res;

    always_comb begin
        special  = 1'b0;
        spec_res = '0;
        spec_dbz = 1'b0;
        spec_inv = 1'b0;
        if (is_div) begin
            if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) ||
                (ca == INF && cb == INF)) begin
                special  = 1'b1;
                spec_res = QNAN;
                spec_inv = 1'b1;
            end else if (cb == ZERO) begin
                // inf/0 is an exact infinity, only finite/0 raises the flag
                special  = 1'b1;
                spec_res = {sq, POS_INF[WW-2:0]};
                spec_dbz = (ca == NORMAL);
            end else if (ca == ZERO || cb == INF) begin
                special  = 1'b1;
                spec_res = {sq, {(WW-1){1'b0}}};
            end else if (ca == INF) begin
                special  = 1'b1;
                spec_res = {sq, POS_INF[WW-2:0]};
            end
        end else begin
            if (ca == NAN) begin
                special  = 1'b1;
                spec_res = QNAN;
                spec_inv = 1'b1;
            end else if (ca == ZERO) begin
                special  = 1'b1;
                spec_res = {sa, {(WW-1){1'b0}}};
            end else if (sa) begin
                special  = 1'b1;
                spec_res = QNAN;
                spec_inv = 1'b1;
            end else if (ca == INF) begin
                special  = 1'b1;
                spec_res = POS_INF;
            end
        end
    end

    // Exponents. An odd unbiased sqrt exponent is made even by doubling the
    // radicand, so the root exponent is an exact halving.
    logic signed [XW-1:0] ea_x, eb_x, u_x, u_adj, div_e, sqrt_e;
    logic                 odd;

    assign ea_x   = $signed({2'b00, ea});
    assign eb_x   = $signed({2'b00, eb});
    assign div_e  = ea_x - eb_x + BIAS_X;
    assign u_x    = ea_x - BIAS_X;
    assign odd    = u_x[0];
    assign u_adj  = odd ? u_x - ONE_X : u_x;
    assign sqrt_e = (u_adj >>> 1) + BIAS_X;

    // One restoring step for each operation.
    logic [RW-1:0] mb_x, div_diff, sq_sh, sq_trial, sq_diff;
    logic          qbit;

    assign mb_x     = {2'b00, mb};
    assign div_diff = rem - mb_x;
    // next two radicand bits enter the partial remainder; trial = 4*root+1
    assign sq_sh    = {rem[RW-3:0], rad[SW-1 -: 2]};
    assign sq_trial = {1'b0, q[MAN_W-1:0], 2'b01};
    assign sq_diff  = sq_sh - sq_trial;
    assign qbit     = is_div ? (rem >= mb_x) : (sq_sh >= sq_trial);

    // Normalize and pack. Divide quotient is in (0.5, 2): a clear top bit
    // means one extra bit of precision and an exponent decrement. The sqrt
    // root always has its leading one in bit MAN_W and never over/underflows.
    logic signed [XW-1:0] e_adj;
    logic [MAN_W-1:0]     frac_d;
    logic [WW-1:0]        norm_res;

    always_comb begin
        e_adj  = q[QW-1] ? exp_r : exp_r - ONE_X;
        frac_d = q[QW-1] ? q[QW-2:1] : q[QW-3:0];
        if (!is_div)
            norm_res = {1'b0, exp_r[EXP_W-1:0], q[MAN_W-1:0]};
        else if (e_adj >= EXP_MAX)
            norm_res = {sign_r, EXP_MAX[EXP_W-1:0], {MAN_W{1'b0}}};
        else if (e_adj <= ZERO_X)
            norm_res = {sign_r, {(WW-1){1'b0}}};
        else
            norm_res = {sign_r, e_adj[EXP_W-1:0], frac_d};
    end

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_any) state_nxt = PREP;
            PREP:    state_nxt = special ? NORM : ITER;
            ITER:    if (cnt == '0) state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            is_div   <= 1'b0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            rem      <= '0;
            q        <= '0;
            rad      <= '0;
            cnt      <= '0;
            result_r <= '0;
            ready_r  <= 1'b1;
            dbz_r    <= 1'b0;
            inv_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_any) begin
                    op_a    <= bus.operand_a;
                    op_b    <= bus.operand_b;
                    is_div  <= bus.div_start;
                    ready_r <= 1'b0;
                    dbz_r   <= 1'b0;
                    inv_r   <= 1'b0;
                end
                PREP: begin
                    sign_r <= sq;
                    exp_r  <= is_div ? div_e : sqrt_e;
                    rem    <= is_div ? {2'b00, ma} : '0;
                    q      <= '0;
                    rad    <= odd ? {ma, {MW{1'b0}}} : {1'b0, ma, {(MW-1){1'b0}}};
                    cnt    <= is_div ? CW'(QW - 1) : CW'(MW - 1);
                end
                ITER: begin
                    q <= {q[QW-2:0], qbit};
                    if (is_div)
                        rem <= qbit ? {div_diff[RW-2:0], 1'b0} : {rem[RW-2:0], 1'b0};
                    else begin
                        rem <= qbit ? sq_diff : sq_sh;
                        rad <= {rad[SW-3:0], 2'b00};
                    end
                    cnt <= cnt - CW'(1);
                end
                NORM: begin
                    result_r <= special ? spec_res : norm_res;
                    dbz_r    <= special & spec_dbz;
                    inv_r    <= special & spec_inv;
                    ready_r  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result          = result_r;
    assign bus.operation_ready = ready_r;
    assign bus.div_by_zero     = dbz_r;
    assign bus.invalid         = inv_r;

endmodule

// File: tb/tb_fpu_divsqrt_unit.sv
// Directed bench for fpu_divsqrt_unit: a vector table of hand-computed
// results and latencies, plus sequences for start-while-busy, simultaneous
// starts and reset during iteration.
module tb_fpu_divsqrt_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_divsqrt_unit_if bus ();

    fpu_divsqrt_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        logic        inv;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Called #1 after a rising edge; counts edges until ready rises.
    task automatic wait_ready(input int n0, output int n);
        n = n0;
        while (!bus.operation_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Issues one start pulse and returns start-edge-to-ready latency.
    task automatic do_op(input logic d, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        bus.div_start  = d;
        bus.sqrt_start = s;
        bus.operand_a  = a;
        bus.operand_b  = b;
        @(posedge clk);
        #1;
        bus.div_start  = 1'b0;
        bus.sqrt_start = 1'b0;
        wait_ready(0, lat);
    endtask

    initial begin
        int lat;
        int n;

        vecs[0]  = '{1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27}; // 6/2
        vecs[1]  = '{1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 27}; // 1/3 trunc
        vecs[2]  = '{1'b0, 32'h41800000, 32'h00000000, 32'h40800000, 1'b0, 1'b0, 26}; // sqrt 16
        vecs[3]  = '{1'b0, 32'h40000000, 32'h12345678, 32'h3FB504F3, 1'b0, 1'b0, 26}; // sqrt 2
        vecs[4]  = '{1'b1, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 2};  // 1/0
        vecs[5]  = '{1'b0, 32'hC0800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 2};  // sqrt -4
        vecs[6]  = '{1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 2};  // sqrt -0
        vecs[7]  = '{1'b1, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 2};  // 0/0
        vecs[8]  = '{1'b1, 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 27}; // -6/2
        vecs[9]  = '{1'b1, 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 27}; // overflow
        vecs[10] = '{1'b1, 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 27}; // underflow
        vecs[11] = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 2};  // sqrt inf
        vecs[12] = '{1'b1, 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2};  // 1/inf
        vecs[13] = '{1'b0, 32'h3E800000, 32'h00000000, 32'h3F000000, 1'b0, 1'b0, 26}; // sqrt 0.25
        vecs[14] = '{1'b1, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2};  // denorm/1
        vecs[15] = '{1'b1, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2};  // NaN/1

        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.sqrt_start = 1'b0;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset ready",  32'(bus.operation_ready), 32'd1);
        chk("reset result", bus.result,               32'h0);
        chk("reset dbz",    32'(bus.div_by_zero),     32'd0);
        chk("reset inv",    32'(bus.invalid),         32'd0);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].is_div, ~vecs[i].is_div, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d result", i),  bus.result,           vecs[i].res);
            chk($sformatf("v%0d dbz", i),     32'(bus.div_by_zero), 32'(vecs[i].dbz));
            chk($sformatf("v%0d invalid", i), 32'(bus.invalid),     32'(vecs[i].inv));
            chk($sformatf("v%0d latency", i), 32'(lat),             32'(vecs[i].lat));
        end

        // result holds in IDLE
        repeat (3) @(posedge clk);
        #1;
        chk("hold result", bus.result, 32'h7FC00000);
        chk("hold inv",    32'(bus.invalid), 32'd1);

        // sqrt_start during a divide is ignored, operands not re-sampled
        bus.div_start = 1'b1;
        bus.operand_a = 32'h40C00000;
        bus.operand_b = 32'h40000000;
        @(posedge clk);
        #1;
        bus.div_start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("busy ready low", 32'(bus.operation_ready), 32'd0);
        bus.sqrt_start = 1'b1;
        bus.operand_a  = 32'h41800000;
        bus.operand_b  = 32'h00000000;
        @(posedge clk);
        #1;
        bus.sqrt_start = 1'b0;
        wait_ready(5, n);
        chk("busy latency", 32'(n), 32'd27);
        chk("busy result",  bus.result, 32'h40400000);
        chk("busy dbz",     32'(bus.div_by_zero), 32'd0);

        // simultaneous starts: divide wins
        do_op(1'b1, 1'b1, 32'h40C00000, 32'h40000000, lat);
        chk("both result",  bus.result, 32'h40400000);
        chk("both latency", 32'(lat), 32'd27);

        // reset during ITER aborts the operation
        bus.div_start = 1'b1;
        bus.operand_a = 32'h3F800000;
        bus.operand_b = 32'h40400000;
        @(posedge clk);
        #1;
        bus.div_start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ready",  32'(bus.operation_ready), 32'd1);
        chk("abort result", bus.result, 32'h0);
        chk("abort dbz",    32'(bus.div_by_zero), 32'd0);
        chk("abort inv",    32'(bus.invalid), 32'd0);
        rst = 1'b0;
        do_op(1'b0, 1'b1, 32'h41800000, 32'h00000000, lat);
        chk("after abort result",  bus.result, 32'h40800000);
        chk("after abort latency", 32'(lat), 32'd26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
